// File: rtl/stepper_pkg.sv
// Shared types and constants for the step/dir receive path.
package stepper_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW = 2'd0,
      HIGH     = 2'd1,
      COMMIT   = 2'd2
   } dec_state_t;

   localparam int FLT_GLITCH  = 0;
   localparam int FLT_DIR_CHG = 1;

   localparam int POS_W = 24;
   localparam int PER_W = 21;

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser for one asynchronous input bit, reset to 0.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[N-2:0], d};
   end

   assign q = r_sync[N-1];

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: synchronises, rejects glitches, tracks position and step period.
// Optional period/speed tracking is built only when STEP_DEC_PERIOD_EN is defined.
module step_dir_decoder
   import stepper_pkg::*;
#(
   parameter int POS_W       = stepper_pkg::POS_W,
   parameter int PER_W       = stepper_pkg::PER_W,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_HIGH    = 25,
   parameter int TIMEOUT     = 2_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_in,
   input  logic             dir_in,
   input  logic             clear,
   input  logic             fault_clr,
   output logic [POS_W-1:0] position,
   output logic [PER_W-1:0] period,
   output logic             period_valid,
   output logic             moving,
   output logic             step_seen,
   output logic [1:0]       fault,
   output dec_state_t       o_dbg_state
);

   localparam int HW = $clog2(MIN_HIGH + 1);
   localparam int FW = $clog2(SYNC_STAGES + 1);

   logic             w_s_step, w_s_dir;
   dec_state_t       r_state, w_next;
   logic             w_rise, w_start;
   logic [1:0]       w_flt_set;
   logic             r_dir_lat;
   logic [HW-1:0]    r_hcnt;
   logic [FW-1:0]    r_fill;
   logic             r_armed;
   logic [POS_W-1:0] r_position;
   logic             r_step_seen;
   logic [1:0]       r_fault;

   sync_ff #(.N(SYNC_STAGES)) u_sync_step (.clk(clk), .rst_n(reset), .d(step_in), .q(w_s_step));
   sync_ff #(.N(SYNC_STAGES)) u_sync_dir  (.clk(clk), .rst_n(reset), .d(dir_in),  .q(w_s_dir));

   // A pulse already high when the synchroniser refills after reset is ignored until it falls.
   assign w_rise = w_s_step & r_armed;

   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_flt_set = 2'b00;
      case (r_state)
         IDLE_LOW: begin
            if (w_rise) begin
               w_next  = HIGH;
               w_start = 1'b1;
            end
         end
         HIGH: begin
            // The high cycle seen in IDLE_LOW counts, so hcnt lags the width by one.
            if (!w_s_step) begin
               if (r_hcnt >= HW'(MIN_HIGH - 1)) begin
                  w_next = COMMIT;
               end else begin
                  w_next                = IDLE_LOW;
                  w_flt_set[FLT_GLITCH] = 1'b1;
               end
            end else if (w_s_dir != r_dir_lat) begin
               w_flt_set[FLT_DIR_CHG] = 1'b1;
            end
         end
         COMMIT: begin
            if (w_rise) begin
               w_next  = HIGH;
               w_start = 1'b1;
            end else begin
               w_next = IDLE_LOW;
            end
         end
         default: w_next = IDLE_LOW;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE_LOW;
         r_dir_lat   <= 1'b0;
         r_hcnt      <= '0;
         r_fill      <= '0;
         r_armed     <= 1'b0;
         r_position  <= '0;
         r_step_seen <= 1'b0;
         r_fault     <= 2'b00;
      end else begin
         r_state <= w_next;
         if (r_fill != FW'(SYNC_STAGES)) r_fill  <= r_fill + FW'(1);
         else if (!w_s_step)             r_armed <= 1'b1;
         if (w_start) begin
            r_dir_lat <= w_s_dir;
            r_hcnt    <= '0;
         end else if (r_state == HIGH && r_hcnt != HW'(MIN_HIGH)) begin
            r_hcnt <= r_hcnt + HW'(1);
         end
         r_step_seen <= (r_state == COMMIT);
         if (clear)                  r_position <= '0;
         else if (r_state == COMMIT) r_position <= r_dir_lat ? r_position - POS_W'(1)
                                                             : r_position + POS_W'(1);
         r_fault <= (fault_clr ? 2'b00 : r_fault) | w_flt_set;
      end
   end

   assign position    = r_position;
   assign step_seen   = r_step_seen;
   assign fault       = r_fault;
   assign o_dbg_state = r_state;

`ifdef STEP_DEC_PERIOD_EN
   localparam logic [PER_W-1:0] TMO = PER_W'(TIMEOUT);

   logic [PER_W-1:0] r_pcnt, r_period;
   logic             r_valid, r_moving, r_prev;

   // r_prev marks that a step has been seen since reset or the last timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcnt   <= TMO;
         r_period <= '0;
         r_valid  <= 1'b0;
         r_moving <= 1'b0;
         r_prev   <= 1'b0;
      end else if (r_state == COMMIT) begin
         r_pcnt   <= '0;
         r_moving <= 1'b1;
         r_prev   <= 1'b1;
         if (r_pcnt < TMO && r_prev) begin
            r_period <= r_pcnt + PER_W'(1);
            r_valid  <= 1'b1;
         end
      end else if (r_pcnt != TMO) begin
         r_pcnt <= r_pcnt + PER_W'(1);
         if (r_pcnt == TMO - PER_W'(1)) begin
            r_valid  <= 1'b0;
            r_moving <= 1'b0;
            r_prev   <= 1'b0;
         end
      end
   end

   assign period       = r_period;
   assign period_valid = r_valid;
   assign moving       = r_moving;
`else
   assign period       = '0;
   assign period_valid = 1'b0;
   assign moving       = 1'b0;
`endif

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: vector table of pulse trains plus hand-written corner sequences.
module tb_step_dir_decoder;
   import stepper_pkg::*;

   localparam int MIN_HIGH = 25;
   localparam int TIMEOUT  = 3000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        step_in = 1'b0;
   logic        dir_in = 1'b0;
   logic        clear = 1'b0;
   logic        fault_clr = 1'b0;
   logic [23:0] position;
   logic [20:0] period;
   logic        period_valid, moving, step_seen;
   logic [1:0]  fault;
   dec_state_t  dbg_state;

   step_dir_decoder #(
      .POS_W(24), .PER_W(21), .SYNC_STAGES(2), .MIN_HIGH(MIN_HIGH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
      .clear(clear), .fault_clr(fault_clr), .position(position), .period(period),
      .period_valid(period_valid), .moving(moving), .step_seen(step_seen),
      .fault(fault), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          seen_cnt = 0;
   int          exp_seen = 0;
   logic [23:0] exp_q[$];
   logic [23:0] model_pos = '0;
   logic [1:0]  model_fault = 2'b00;
   logic [23:0] mon_exp;

   typedef struct {
      bit          pre_reset;
      int          n;
      int          hi;
      int          lo;
      logic        dir;
      logic [23:0] exp_pos;
      logic [1:0]  exp_fault;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: each step_seen pops the position expected for that step.
   always @(negedge clk) begin
      if (reset && step_seen) begin
         seen_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_step: got step_seen=1 position=0x%0h expected no step", position);
         end else begin
            mon_exp = exp_q.pop_front();
            check("step_pos", 32'(position), 32'(mon_exp));
         end
      end
   end

   task automatic pulse(input int hi, input int lo, input logic d);
      @(negedge clk);
      dir_in  = d;
      step_in = 1'b1;
      repeat (hi) @(negedge clk);
      step_in = 1'b0;
      if (hi >= MIN_HIGH) begin
         model_pos = d ? model_pos - 24'd1 : model_pos + 24'd1;
         exp_q.push_back(model_pos);
         exp_seen++;
      end else begin
         model_fault[0] = 1'b1;
      end
      repeat (lo - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_pos   = '0;
      model_fault = 2'b00;
      exp_q.delete();
   endtask

   initial begin
      vecs[0] = '{1'b0, 10, 50, 1000, 1'b0, 24'd10,     2'b00};
      vecs[1] = '{1'b1, 3,  50, 200,  1'b1, 24'hFFFFFD, 2'b00};
      vecs[2] = '{1'b0, 3,  50, 200,  1'b0, 24'd0,      2'b00};
      vecs[3] = '{1'b0, 1,  10, 200,  1'b0, 24'd0,      2'b01};
      vecs[4] = '{1'b0, 1,  25, 200,  1'b0, 24'd1,      2'b01};
      vecs[5] = '{1'b0, 1,  24, 200,  1'b0, 24'd1,      2'b01};
      vecs[6] = '{1'b0, 4,  25, 1,    1'b1, 24'hFFFFFD, 2'b01};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_position", 32'(position), 32'd0);
      check("rst_step_seen", 32'(step_seen), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE_LOW));
      reset = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].pre_reset) do_reset();
         for (int p = 0; p < vecs[i].n; p++) pulse(vecs[i].hi, vecs[i].lo, vecs[i].dir);
         repeat (10) @(negedge clk);
         check($sformatf("vec%0d_position", i), 32'(position), 32'(vecs[i].exp_pos));
         check($sformatf("vec%0d_model_pos", i), 32'(position), 32'(model_pos));
         check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
         if (i == 0) begin
`ifdef STEP_DEC_PERIOD_EN
            check("basic_period", 32'(period), 32'd1050);
            check("basic_period_valid", 32'(period_valid), 32'd1);
            check("basic_moving", 32'(moving), 32'd1);
`else
            check("basic_period", 32'(period), 32'd0);
            check("basic_period_valid", 32'(period_valid), 32'd0);
            check("basic_moving", 32'(moving), 32'd0);
`endif
            check("basic_seen_cnt", 32'(seen_cnt), 32'd10);
         end
      end

      // fault_clr clears the sticky glitch bit
      @(negedge clk) fault_clr = 1'b1;
      @(negedge clk) fault_clr = 1'b0;
      model_fault = 2'b00;
      check("fault_clr", 32'(fault), 32'd0);

      // dir toggles mid-pulse: count uses the latched dir, fault[1] sets
      @(negedge clk);
      dir_in  = 1'b0;
      step_in = 1'b1;
      repeat (20) @(negedge clk);
      dir_in = 1'b1;
      repeat (30) @(negedge clk);
      step_in = 1'b0;
      model_pos = model_pos + 24'd1;
      exp_q.push_back(model_pos);
      exp_seen++;
      model_fault[1] = 1'b1;
      repeat (100) @(negedge clk);
      check("dirchg_position", 32'(position), 32'hFFFFFE);
      check("dirchg_fault", 32'(fault), 32'(model_fault));

`ifdef STEP_DEC_PERIOD_EN
      check("pre_tmo_moving", 32'(moving), 32'd1);
      repeat (TIMEOUT + 100) @(negedge clk);
      check("tmo_moving", 32'(moving), 32'd0);
      check("tmo_period_valid", 32'(period_valid), 32'd0);
      pulse(50, 500, 1'b0);
      check("tmo_first_valid", 32'(period_valid), 32'd0);
      check("tmo_first_moving", 32'(moving), 32'd1);
      pulse(50, 500, 1'b0);
      check("tmo_second_valid", 32'(period_valid), 32'd1);
      check("tmo_second_period", 32'(period), 32'd550);
`endif

      // clear lands in the COMMIT cycle: fall at N0, COMMIT sampled at the 4th edge
      @(negedge clk);
      dir_in  = 1'b0;
      step_in = 1'b1;
      repeat (50) @(negedge clk);
      step_in = 1'b0;
      model_pos = '0;
      exp_q.push_back(model_pos);
      exp_seen++;
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk) clear = 1'b0;
      repeat (10) @(negedge clk);
      check("clear_commit_position", 32'(position), 32'd0);

      // reset for one cycle in the middle of a high phase
      pulse(50, 100, 1'b0);
      check("pre_rst_position", 32'(position), 32'd1);
      @(negedge clk);
      step_in = 1'b1;
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_position", 32'(position), 32'd0);
      check("midrst_fault", 32'(fault), 32'd0);
      check("midrst_period", 32'(period), 32'd0);
      check("midrst_period_valid", 32'(period_valid), 32'd0);
      check("midrst_moving", 32'(moving), 32'd0);
      check("midrst_step_seen", 32'(step_seen), 32'd0);
      @(negedge clk) reset = 1'b1;
      model_pos   = '0;
      model_fault = 2'b00;
      repeat (40) @(negedge clk);
      step_in = 1'b0;
      repeat (100) @(negedge clk);
      check("midrst_pulse_ignored", 32'(position), 32'd0);
      pulse(50, 100, 1'b0);
      check("post_rst_pulse", 32'(position), 32'd1);

      check("seen_total", 32'(seen_cnt), 32'(exp_seen));
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
